// File: rtl/multdiv_pkg.sv
// Shared constants and encodings for the multdiv front end and the
// multiply issue sequencer.
package multdiv_pkg;

    localparam int unsigned TAG_W    = 5;
    localparam int unsigned MULT_LAT = 4;

    typedef enum logic [1:0] {
        KIND_SINGLE = 2'd0,
        KIND_LO     = 2'd1,
        KIND_HI     = 2'd2
    } pass_kind_t;

    typedef enum logic {
        ST_ISSUE    = 1'b0,
        ST_ISSUE_HI = 1'b1
    } seq_state_t;

    // True when the operand fits the multiplier's signed 16-bit B input.
    function automatic logic fits_s16(input logic [31:0] b);
        return (b[31:15] == '0) || (b[31:15] == '1);
    endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Request/result bundle between the multdiv front end and the sequencer.
interface mult_sequencer_if #(
    parameter int unsigned TAG_W = multdiv_pkg::TAG_W
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_A;
    logic [31:0]      req_B;
    logic [TAG_W-1:0] req_tag;
    logic             res_valid;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_exception;

    modport master (
        output req_valid, req_A, req_B, req_tag,
        input  req_ready, res_valid, res_data, res_tag, res_exception
    );

    modport slave (
        input  req_valid, req_A, req_B, req_tag,
        output req_ready, res_valid, res_data, res_tag, res_exception
    );
endinterface

// File: rtl/mult_tag_pipe.sv
// Shadow shift register of {valid, kind, tag} tracking passes in flight
// through the multiplier; async clear drops everything in flight.
module mult_tag_pipe
    import multdiv_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  pass_kind_t       in_kind,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output pass_kind_t       out_kind,
    output logic [TAG_W-1:0] out_tag
);

    logic [DEPTH-1:0] valid_q;
    pass_kind_t       kind_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                kind_q[i] <= KIND_SINGLE;
                tag_q[i]  <= '0;
            end
        end else begin
            valid_q   <= {valid_q[DEPTH-2:0], in_valid};
            kind_q[0] <= in_kind;
            tag_q[0]  <= in_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                kind_q[i] <= kind_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_kind  = kind_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/mult_sequencer.sv
// Issue-side controller for the 32x16 pipelined Booth multiplier: splits
// 32x32 requests into one or two passes and recombines the partial products.
module mult_sequencer #(
    parameter int unsigned TAG_W    = multdiv_pkg::TAG_W,
    parameter int unsigned MULT_LAT = multdiv_pkg::MULT_LAT
) (
    input  logic                clock,
    input  logic                reset,
    mult_sequencer_if.slave     bus,
    output logic [31:0]         mult_data_A,
    output logic [15:0]         mult_data_B,
    output logic                mult_signal,
    input  logic [31:0]         mult_result,
    input  logic                mult_exception
);
    import multdiv_pkg::*;

    seq_state_t       state_q, state_d;
    logic             accept;
    logic             issue_en;
    logic [31:0]      issue_A;
    logic [15:0]      issue_B;
    pass_kind_t       issue_kind;
    logic [TAG_W-1:0] issue_tag;
    logic             save_en;

    logic [31:0]      save_A;
    logic [15:0]      save_B_hi;
    logic [TAG_W-1:0] save_tag;

    logic             ent_valid;
    pass_kind_t       ent_kind;
    logic [TAG_W-1:0] ent_tag;

    logic             tail_valid;
    pass_kind_t       tail_kind;
    logic [TAG_W-1:0] tail_tag;

    logic [31:0]      lo_hold;
    logic             res_valid_q;
    logic [31:0]      res_data_q;
    logic [TAG_W-1:0] res_tag_q;
    logic             res_exc_q;

    assign bus.req_ready = (state_q == ST_ISSUE);
    assign accept        = bus.req_valid && (state_q == ST_ISSUE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_ISSUE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        issue_en   = 1'b0;
        issue_A    = bus.req_A;
        issue_B    = bus.req_B[15:0];
        issue_kind = KIND_SINGLE;
        issue_tag  = bus.req_tag;
        save_en    = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                if (accept) begin
                    issue_en = 1'b1;
                    if (!fits_s16(bus.req_B)) begin
                        issue_kind = KIND_LO;
                        save_en    = 1'b1;
                        state_d    = ST_ISSUE_HI;
                    end
                end
            end
            ST_ISSUE_HI: begin
                issue_en   = 1'b1;
                issue_A    = save_A;
                issue_B    = save_B_hi;
                issue_kind = KIND_HI;
                issue_tag  = save_tag;
                state_d    = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    // HI half absorbs the borrow introduced by treating B[15:0] as signed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            save_A    <= '0;
            save_B_hi <= '0;
            save_tag  <= '0;
        end else if (save_en) begin
            save_A    <= bus.req_A;
            save_B_hi <= bus.req_B[31:16] + 16'(bus.req_B[15]);
            save_tag  <= bus.req_tag;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mult_signal <= 1'b0;
            mult_data_A <= '0;
            mult_data_B <= '0;
            ent_valid   <= 1'b0;
            ent_kind    <= KIND_SINGLE;
            ent_tag     <= '0;
        end else begin
            mult_signal <= issue_en;
            ent_valid   <= issue_en;
            ent_kind    <= issue_kind;
            ent_tag     <= issue_tag;
            if (issue_en) begin
                mult_data_A <= issue_A;
                mult_data_B <= issue_B;
            end
        end
    end

    // The entry register plus MULT_LAT+1 stages line the tail up with the
    // multiplier output for the pass issued alongside it.
    mult_tag_pipe #(
        .DEPTH (MULT_LAT + 1),
        .TAG_W (TAG_W)
    ) u_tag_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (ent_valid),
        .in_kind   (ent_kind),
        .in_tag    (ent_tag),
        .out_valid (tail_valid),
        .out_kind  (tail_kind),
        .out_tag   (tail_tag)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_exc_q   <= 1'b0;
            lo_hold     <= '0;
        end else begin
            res_valid_q <= 1'b0;
            if (tail_valid) begin
                case (tail_kind)
                    KIND_SINGLE: begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= mult_result;
                        res_exc_q   <= mult_exception;
                        res_tag_q   <= tail_tag;
                    end
                    KIND_LO: lo_hold <= mult_result;
                    KIND_HI: begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= lo_hold + {mult_result[15:0], 16'h0000};
                        res_exc_q   <= 1'b0;
                        res_tag_q   <= tail_tag;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.res_valid     = res_valid_q;
    assign bus.res_data      = res_data_q;
    assign bus.res_tag       = res_tag_q;
    assign bus.res_exception = res_exc_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural 4-stage multiplier
// and an in-order scoreboard of expected products, tags and latencies.
module tb_mult_sequencer;

    localparam int unsigned TW = 5;

    logic        clock;
    logic        reset;
    logic [31:0] mult_data_A;
    logic [15:0] mult_data_B;
    logic        mult_signal;
    logic [31:0] mult_result;
    logic        mult_exception;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    mult_sequencer_if #(.TAG_W(TW)) bus ();

    mult_sequencer #(.TAG_W(TW), .MULT_LAT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .mult_data_A    (mult_data_A),
        .mult_data_B    (mult_data_B),
        .mult_signal    (mult_signal),
        .mult_result    (mult_result),
        .mult_exception (mult_exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Multiplier model: captures one edge after load, valid 4 edges later; no reset.
    logic signed [47:0] m_full;
    logic [31:0]        mp [5];
    logic               me [5];
    assign m_full = 48'($signed(mult_data_A)) * 48'($signed(mult_data_B));
    always @(posedge clock) begin
        mp[0] <= m_full[31:0];
        me[0] <= !((&m_full[47:31]) || !(|m_full[47:31]));
        for (int i = 1; i < 5; i++) begin
            mp[i] <= mp[i-1];
            me[i] <= me[i-1];
        end
    end
    assign mult_result    = mp[4];
    assign mult_exception = me[4];

    typedef struct {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        logic          exc;
        int            acc;
        int            lat;
    } sb_t;
    sb_t sb [$];
    sb_t mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ovf32(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] f;
        f = 64'($signed(a)) * 64'($signed(b));
        return (f > 64'sd2147483647) || (f < -64'sd2147483648);
    endfunction

    function automatic bit is_double(input logic [31:0] b);
        return ($signed(b) > 32'sd32767) || ($signed(b) < -32'sd32768);
    endfunction

    always @(negedge clock) begin
        if (!reset && bus.res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_res_valid", 64'(bus.res_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("res_data", 64'(bus.res_data), 64'(mon_e.data));
                chk("res_tag", 64'(bus.res_tag), 64'(mon_e.tag));
                chk("res_exception", 64'(bus.res_exception), 64'(mon_e.exc));
                chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t,
                        input logic [31:0] exp_d, input logic exp_e);
        int n;
        bit dbl;
        dbl = is_double(b);
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("ready_before_req", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_A     = a;
        bus.req_B     = b;
        bus.req_tag   = t;
        @(posedge clock); #1;
        sb.push_back('{exp_d, t, dbl ? 1'b0 : exp_e, cyc, dbl ? 7 : 6});
        bus.req_valid = 1'b0;
        if (dbl) begin
            chk("ready_issue_hi", 64'(bus.req_ready), 64'd0);
            @(posedge clock); #1;
            chk("ready_after_hi", 64'(bus.req_ready), 64'd1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string ph);
        chk({ph, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({ph, "_mult_signal"}, 64'(mult_signal), 64'd0);
        chk({ph, "_mult_data_A"}, 64'(mult_data_A), 64'd0);
        chk({ph, "_mult_data_B"}, 64'(mult_data_B), 64'd0);
        chk({ph, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        chk({ph, "_res_data"}, 64'(bus.res_data), 64'd0);
        chk({ph, "_res_tag"}, 64'(bus.res_tag), 64'd0);
        chk({ph, "_res_exception"}, 64'(bus.res_exception), 64'd0);
    endtask

    logic [31:0] st_a [20] = '{
        32'h0000_0003, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0100, 32'hDEAD_BEEF,
        32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hCAFE_BABE, 32'h8000_0000,
        32'h0001_0001, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0000_FFFF, 32'h0000_0001,
        32'h1000_0000, 32'h8765_4321, 32'hFFFF_FFF0, 32'h0000_7FFF, 32'h0012_3456};
    logic [31:0] st_b [20] = '{
        32'h0001_0000, 32'h0000_7FFF, 32'h8000_0000, 32'hFFFF_8000, 32'h0000_8000,
        32'hFFFF_8001, 32'hFFFF_7FFF, 32'h0000_0001, 32'h1234_ABCD, 32'hFFFF_FFFF,
        32'h7FFF_FFFF, 32'h0000_1234, 32'h5A5A_5A5A, 32'h0000_0002, 32'hFFFE_FFFF,
        32'h0000_0010, 32'h0F0F_F0F0, 32'hFFFF_FFF0, 32'h8000_8000, 32'h0000_0700};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_A     = '0;
        bus.req_B     = '0;
        bus.req_tag   = '0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_outputs("por");
        reset = 1'b0;
        @(posedge clock); #1;

        // SINGLE 7 * -3
        send(32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0);
        drain();

        // DOUBLE: 0x1234 * 0x18000 = 0x1B4E0000
        send(32'h0000_1234, 32'h0001_8000, 5'd9, 32'h1B4E_0000, 1'b0);
        drain();

        // Four back-to-back SINGLEs
        send(32'd10, 32'd3, 5'd1, 32'd30, 1'b0);
        send(32'hFFFF_FFFE, 32'd100, 5'd2, 32'hFFFF_FF38, 1'b0);
        send(32'h0001_0000, 32'h0000_7FFF, 5'd3, 32'h7FFF_0000, 1'b0);
        send(32'd255, 32'hFFFF_8000, 5'd4, 32'hFF80_8000, 1'b0);
        drain();

        // SINGLE overflow
        send(32'h4000_0000, 32'd4, 5'd17, 32'h0000_0000, 1'b1);
        drain();

        // Alternating DOUBLE/SINGLE stream
        for (int i = 0; i < 20; i++)
            send(st_a[i], st_b[i], 5'(i + 8), st_a[i] * st_b[i], ovf32(st_a[i], st_b[i]));
        drain();

        // Reset three cycles into a DOUBLE; in-flight passes must vanish
        send(32'h0000_1234, 32'h0001_8000, 5'd30, 32'h1B4E_0000, 1'b0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk_reset_outputs("mid");
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("no_res_after_reset", 64'(bus.res_valid), 64'd0);
        end
        chk("post_reset_ready", 64'(bus.req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
